mc_ctrl_unit: RTL and testbench
===============================

MC_CTRL_UNIT -- requirements
Module: mc_ctrl_unit

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, which is the maximum number of cycles a memory wait may last.
REQ-002 SHALL have parameter RET_W, default 16, which is the width of the retired-instruction counter.
REQ-003 clk  in  1  single clock, rising edge.
REQ-004 reset  in  1  asynchronous, active-low.
REQ-005 Op  in  6  opcode of the latched IR.
REQ-006 Func  in  6  funct field of the latched IR.
REQ-007 rs  in  5  rs field of the latched IR (distinguishes mfc0/mtc0).
REQ-008 alu_zero  in  1  ALU equal flag, valid in EX.
REQ-009 mem_ready  in  1  memory handshake done.
REQ-010 state  out  3  IF=0, ID=1, EX=2, MEM=3, WB=4, EXC=5.
REQ-011 mem_req  out  1  memory request.
REQ-012 IRwrite  out  1  IR load strobe.
REQ-013 PCwrite  out  1  PC load strobe.
REQ-014 PCsel  out  4  NORMAL=0, BEQ=1, JAL=2, JR=3, ERET=4, EXCV=5.
REQ-015 Regwrite  out  1  GPR write strobe.
REQ-016 Memwrite  out  1  data-memory write.
REQ-017 cp0_we  out  1  CP0 write strobe.
REQ-018 RegDst/ALUSrc/memtoReg  out  2 each  datapath selects, decoded as in single-cycle CU.
REQ-019 Extop/ALUop  out  8 each  extender and ALU op, decoded as in single-cycle CU.
REQ-020 exc_req  out  1  exception pulse.
REQ-021 exc_code  out  5  cause: 8=syscall, 10=reserved instruction, 7=memory timeout.
REQ-022 retired  out  RET_W  count of completed instructions.

Function
REQ-023 The unit SHALL decode add, sub, ori, lui, lw, sw, beq, jal, jr, syscall, mfc0, mtc0, eret; any other encoding SHALL be decoded as nop.
REQ-024 Decode selects SHALL be combinational from Op/Func/rs; every strobe SHALL be qualified by state.
REQ-025 IF SHALL assert mem_req; on mem_ready it SHALL pulse IRwrite and PCwrite (PCsel=NORMAL) and go to ID.
REQ-026 ID SHALL always go to EX after one cycle, with no strobes.
REQ-027 EX exits by instruction: beq goes to IF, with PCwrite=alu_zero and PCsel=BEQ; jr/eret go to IF with PCwrite and PCsel=JR/ERET; jal goes to WB with PCwrite and PCsel=JAL; add/sub/ori/lui/mfc0 go to WB; lw/sw go to MEM; mtc0 pulses cp0_we and goes to IF; nop goes to IF; syscall follows REQ-040.
REQ-028 MEM SHALL assert mem_req; sw SHALL hold Memwrite for the whole wait; on mem_ready, lw goes to WB and sw goes to IF.
REQ-029 WB SHALL pulse Regwrite for exactly one cycle and go to IF.
REQ-030 retired SHALL increment on every transition into IF from EX, MEM or WB, and SHALL wrap at 2^RET_W-1 to 0.
REQ-031 Latency SHALL be: lw 5 cycles, sw/add/jal 4, beq/jr 3, each plus memory wait cycles.
REQ-032 mem_ready outside IF/MEM SHALL be ignored.
REQ-033 mem_ready in the first cycle of IF/MEM SHALL complete with zero wait.

Reset
REQ-034 While reset=0, the unit SHALL be in state IF with retired=0, wait counter=0, and all strobes, mem_req and exc_req at 0.
REQ-035 Reset asserted mid-MEM SHALL immediately drop Memwrite and mem_req; no partial write SHALL be retried.
REQ-036 After reset release, the first IF SHALL assert mem_req on the next cycle.

Configuration
REQ-037 The macro MC_CTRL_UNIT_EXC_EN SHALL compile in the EXC state, the wait counter, exc_req and exc_code.
REQ-038 With the macro defined: a wait counter SHALL count cycles in IF/MEM, and reaching TIMEOUT without mem_ready SHALL go to EXC with code 7; Memwrite SHALL drop in that same cycle.
REQ-039 With the macro defined: a reserved instruction in EX SHALL go to EXC with code 10.
REQ-040 With the macro defined, syscall in EX SHALL go to EXC with code 8; without it, syscall SHALL retire as nop.
REQ-041 EXC SHALL last one cycle, pulsing exc_req and PCwrite with PCsel=EXCV, go to IF, and leave retired unchanged.
REQ-042 Without the macro, exc_req and exc_code SHALL be tied 0, waits SHALL be unbounded, and reserved instructions SHALL behave as nop.

Verification
REQ-043 Reset, then lw with mem_ready high every cycle: states IF,ID,EX,MEM,WB; Regwrite only in cycle 5; retired=1.
REQ-044 beq with alu_zero=0, then alu_zero=1: PCwrite in EX only for the second; each takes 3 cycles.
REQ-045 sw with mem_ready delayed 3 cycles: Memwrite high for 4 consecutive cycles, then IF.
REQ-046 EXC_EN defined, TIMEOUT=4, mem_ready held low in IF: EXC after 4 cycles with exc_code=7 and one exc_req pulse.
REQ-047 Reset asserted mid-MEM during sw: Memwrite falls asynchronously, state=0, retired=0.
REQ-048 RET_W=2, run 5 nops: retired sequence 1,2,3,0,1; syscall gives exc_code=8 with the macro and retires as nop without it.

Source files
------------

// File: rtl/mc_ctrl_unit.sv
// Multi-cycle control unit for a small MIPS subset: IF/ID/EX/MEM/WB sequencing, decode selects, retire count.
// Define MC_CTRL_UNIT_EXC_EN to add the EXC state, the memory-wait timeout and exc_req/exc_code reporting.
module mc_ctrl_unit #(
    parameter int TIMEOUT = 16,
    parameter int RET_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       Op,
    input  logic [5:0]       Func,
    input  logic [4:0]       rs,
    input  logic             alu_zero,
    input  logic             mem_ready,
    output logic [2:0]       state,
    output logic             mem_req,
    output logic             IRwrite,
    output logic             PCwrite,
    output logic [3:0]       PCsel,
    output logic             Regwrite,
    output logic             Memwrite,
    output logic             cp0_we,
    output logic [1:0]       RegDst,
    output logic [1:0]       ALUSrc,
    output logic [1:0]       memtoReg,
    output logic [7:0]       Extop,
    output logic [7:0]       ALUop,
    output logic             exc_req,
    output logic [4:0]       exc_code,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4,
        S_EXC = 3'd5
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_ORI = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F, OP_COP0 = 6'h10, OP_LW = 6'h23, OP_SW = 6'h2B;
    localparam logic [5:0] FN_JR = 6'h08, FN_SYSCALL = 6'h0C, FN_ERET = 6'h18, FN_ADD = 6'h20, FN_SUB = 6'h22;
    localparam logic [4:0] RS_MF = 5'h00, RS_MT = 5'h04, RS_CO = 5'h10;

    localparam logic [3:0] PC_NORMAL = 4'd0, PC_BEQ = 4'd1, PC_JAL = 4'd2;
    localparam logic [3:0] PC_JR = 4'd3, PC_ERET = 4'd4, PC_EXCV = 4'd5;

    state_t           r_state;
    logic             r_run;
    logic [RET_W-1:0] r_retired;

    logic w_add, w_sub, w_ori, w_lui, w_lw, w_sw, w_beq, w_jal, w_jr, w_mfc0, w_mtc0, w_eret;
    logic w_timeout;

    assign w_add  = (Op == OP_RTYPE) && (Func == FN_ADD);
    assign w_sub  = (Op == OP_RTYPE) && (Func == FN_SUB);
    assign w_jr   = (Op == OP_RTYPE) && (Func == FN_JR);
    assign w_ori  = (Op == OP_ORI);
    assign w_lui  = (Op == OP_LUI);
    assign w_lw   = (Op == OP_LW);
    assign w_sw   = (Op == OP_SW);
    assign w_beq  = (Op == OP_BEQ);
    assign w_jal  = (Op == OP_JAL);
    assign w_mfc0 = (Op == OP_COP0) && (rs == RS_MF);
    assign w_mtc0 = (Op == OP_COP0) && (rs == RS_MT);
    assign w_eret = (Op == OP_COP0) && (rs == RS_CO) && (Func == FN_ERET);

`ifdef MC_CTRL_UNIT_EXC_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [4:0] EXC_TMO = 5'd7, EXC_SYS = 5'd8, EXC_RI = 5'd10;

    logic [CW-1:0] r_wait;
    logic [4:0]    r_exc_code;
    logic          w_sys, w_known, w_rsv;

    assign w_sys   = (Op == OP_RTYPE) && (Func == FN_SYSCALL);
    assign w_known = w_add | w_sub | w_ori | w_lui | w_lw | w_sw | w_beq | w_jal
                   | w_jr | w_sys | w_mfc0 | w_mtc0 | w_eret;
    // The all-zero Op/Func word is the architectural nop, not a reserved instruction.
    assign w_rsv   = !w_known && !((Op == OP_RTYPE) && (Func == 6'h00));

    assign w_timeout = r_run && ((r_state == S_IF) || (r_state == S_MEM)) && !mem_ready
                     && (r_wait == CW'(TIMEOUT - 1));
    assign exc_req   = (r_state == S_EXC);
    assign exc_code  = r_exc_code;
`else
    assign w_timeout = 1'b0;
    assign exc_req   = 1'b0;
    assign exc_code  = 5'd0;
`endif

    assign state   = r_state;
    assign retired = r_retired;

    // r_run holds everything quiet for the first cycle after reset release
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IF;
            r_run     <= 1'b0;
            r_retired <= '0;
`ifdef MC_CTRL_UNIT_EXC_EN
            r_wait     <= '0;
            r_exc_code <= '0;
`endif
        end else begin
            r_run <= 1'b1;
            case (r_state)
                S_IF: begin
                    if (r_run && mem_ready) begin
                        r_state <= S_ID;
                    end
`ifdef MC_CTRL_UNIT_EXC_EN
                    else if (w_timeout) begin
                        r_state    <= S_EXC;
                        r_exc_code <= EXC_TMO;
                    end
`endif
                end
                S_ID: r_state <= S_EX;
                S_EX: begin
                    if (w_lw || w_sw) begin
                        r_state <= S_MEM;
                    end else if (w_add || w_sub || w_ori || w_lui || w_mfc0 || w_jal) begin
                        r_state <= S_WB;
                    end
`ifdef MC_CTRL_UNIT_EXC_EN
                    else if (w_sys) begin
                        r_state    <= S_EXC;
                        r_exc_code <= EXC_SYS;
                    end else if (w_rsv) begin
                        r_state    <= S_EXC;
                        r_exc_code <= EXC_RI;
                    end
`endif
                    else begin
                        r_state   <= S_IF;
                        r_retired <= r_retired + RET_W'(1);
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_lw) begin
                            r_state <= S_WB;
                        end else begin
                            r_state   <= S_IF;
                            r_retired <= r_retired + RET_W'(1);
                        end
                    end
`ifdef MC_CTRL_UNIT_EXC_EN
                    else if (w_timeout) begin
                        r_state    <= S_EXC;
                        r_exc_code <= EXC_TMO;
                    end
`endif
                end
                S_WB: begin
                    r_state   <= S_IF;
                    r_retired <= r_retired + RET_W'(1);
                end
                default: r_state <= S_IF;
            endcase
`ifdef MC_CTRL_UNIT_EXC_EN
            if (r_run && ((r_state == S_IF) || (r_state == S_MEM)) && !mem_ready && !w_timeout) begin
                r_wait <= r_wait + CW'(1);
            end else begin
                r_wait <= '0;
            end
`endif
        end
    end

    always_comb begin
        mem_req  = 1'b0;
        IRwrite  = 1'b0;
        PCwrite  = 1'b0;
        PCsel    = PC_NORMAL;
        Regwrite = 1'b0;
        Memwrite = 1'b0;
        cp0_we   = 1'b0;
        case (r_state)
            S_IF: begin
                mem_req = r_run;
                IRwrite = r_run && mem_ready;
                PCwrite = r_run && mem_ready;
            end
            S_EX: begin
                if (w_beq) begin
                    PCwrite = alu_zero;
                    PCsel   = PC_BEQ;
                end else if (w_jr) begin
                    PCwrite = 1'b1;
                    PCsel   = PC_JR;
                end else if (w_eret) begin
                    PCwrite = 1'b1;
                    PCsel   = PC_ERET;
                end else if (w_jal) begin
                    PCwrite = 1'b1;
                    PCsel   = PC_JAL;
                end else if (w_mtc0) begin
                    cp0_we = 1'b1;
                end
            end
            S_MEM: begin
                mem_req  = 1'b1;
                Memwrite = w_sw && !w_timeout;
            end
            S_WB:  Regwrite = 1'b1;
            S_EXC: begin
                PCwrite = 1'b1;
                PCsel   = PC_EXCV;
            end
            default: ;
        endcase
    end

    // Datapath selects: RegDst 0=rt 1=rd 2=$31; memtoReg 0=ALU 1=mem 2=PC+4 3=CP0;
    // Extop 0=zero 1=sign 2=lui; ALUop 0=add 1=sub 2=or 3=lui.
    always_comb begin
        RegDst   = 2'd0;
        ALUSrc   = 2'd0;
        memtoReg = 2'd0;
        Extop    = 8'd0;
        ALUop    = 8'd0;
        if (w_add) begin
            RegDst = 2'd1;
        end else if (w_sub) begin
            RegDst = 2'd1;
            ALUop  = 8'd1;
        end else if (w_ori) begin
            ALUSrc = 2'd1;
            ALUop  = 8'd2;
        end else if (w_lui) begin
            ALUSrc = 2'd1;
            Extop  = 8'd2;
            ALUop  = 8'd3;
        end else if (w_lw) begin
            ALUSrc   = 2'd1;
            memtoReg = 2'd1;
            Extop    = 8'd1;
        end else if (w_sw) begin
            ALUSrc = 2'd1;
            Extop  = 8'd1;
        end else if (w_beq) begin
            Extop = 8'd1;
            ALUop = 8'd1;
        end else if (w_jal) begin
            RegDst   = 2'd2;
            memtoReg = 2'd2;
        end else if (w_mfc0) begin
            memtoReg = 2'd3;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_unit.sv
// Testbench for mc_ctrl_unit: table vectors, hand-written reset/wrap sequences and random instructions
// checked against an instruction-phase reference model (TIMEOUT=4, RET_W=2).
module tb_mc_ctrl_unit;

    localparam int TO = 4;
    localparam int RW = 2;
`ifdef MC_CTRL_UNIT_EXC_EN
    localparam bit EXC_ON = 1'b1;
`else
    localparam bit EXC_ON = 1'b0;
`endif

    localparam int C_ADD = 0, C_SUB = 1, C_ORI = 2, C_LUI = 3, C_LW = 4, C_SW = 5, C_BEQ = 6, C_JAL = 7;
    localparam int C_JR = 8, C_SYS = 9, C_MFC0 = 10, C_MTC0 = 11, C_ERET = 12, C_NOP = 13, C_RSV = 14;

    logic          clk, reset;
    logic [5:0]    Op, Func;
    logic [4:0]    rs;
    logic          alu_zero, mem_ready;
    logic [2:0]    state;
    logic          mem_req, IRwrite, PCwrite, Regwrite, Memwrite, cp0_we, exc_req;
    logic [3:0]    PCsel;
    logic [1:0]    RegDst, ALUSrc, memtoReg;
    logic [7:0]    Extop, ALUop;
    logic [4:0]    exc_code;
    logic [RW-1:0] retired;

    mc_ctrl_unit #(.TIMEOUT(TO), .RET_W(RW)) dut (
        .clk(clk), .reset(reset), .Op(Op), .Func(Func), .rs(rs),
        .alu_zero(alu_zero), .mem_ready(mem_ready), .state(state),
        .mem_req(mem_req), .IRwrite(IRwrite), .PCwrite(PCwrite), .PCsel(PCsel),
        .Regwrite(Regwrite), .Memwrite(Memwrite), .cp0_we(cp0_we),
        .RegDst(RegDst), .ALUSrc(ALUSrc), .memtoReg(memtoReg), .Extop(Extop), .ALUop(ALUop),
        .exc_req(exc_req), .exc_code(exc_code), .retired(retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [13:0] w_outs;
    logic [21:0] w_dec;
    assign w_outs = {state, mem_req, IRwrite, PCwrite, PCsel, Regwrite, Memwrite, cp0_we, exc_req};
    assign w_dec  = {RegDst, ALUSrc, memtoReg, Extop, ALUop};

    int n_vec = 0;
    int n_bad = 0;
    int model_ret = 0;

    // Latency monitor: cycles since the current instruction's first active IF cycle
    int         mon_cnt = 0;
    logic [2:0] mon_prev = 3'd7;
    always @(negedge clk) begin
        if (!reset || (state == 3'd0 && !mem_req)) begin
            mon_prev <= 3'd7;
            mon_cnt  <= 0;
        end else begin
            mon_cnt  <= (state == 3'd0 && mon_prev != 3'd0) ? 1 : mon_cnt + 1;
            mon_prev <= state;
        end
    end

    typedef struct {
        int cls;
        int ifw;
        int mw;
        bit az;
        int lat;
        int ret;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc(input string nm, input logic [2:0] st, input logic mq, input logic irw,
                       input logic pcw, input logic [3:0] ps, input logic rw, input logic mw,
                       input logic cp, input logic ex);
        @(negedge clk);
        chk(nm, 32'(w_outs), 32'({st, mq, irw, pcw, ps, rw, mw, cp, ex}));
        @(posedge clk);
        #1;
    endtask

    task automatic set_ir(input int cls);
        rs   = 5'($urandom);
        Func = 6'h15;
        case (cls)
            C_ADD:  begin Op = 6'h00; Func = 6'h20; end
            C_SUB:  begin Op = 6'h00; Func = 6'h22; end
            C_ORI:  Op = 6'h0D;
            C_LUI:  Op = 6'h0F;
            C_LW:   Op = 6'h23;
            C_SW:   Op = 6'h2B;
            C_BEQ:  Op = 6'h04;
            C_JAL:  Op = 6'h03;
            C_JR:   begin Op = 6'h00; Func = 6'h08; end
            C_SYS:  begin Op = 6'h00; Func = 6'h0C; end
            C_MFC0: begin Op = 6'h10; rs = 5'h00; end
            C_MTC0: begin Op = 6'h10; rs = 5'h04; end
            C_ERET: begin Op = 6'h10; rs = 5'h10; Func = 6'h18; end
            C_NOP:  begin Op = 6'h00; Func = 6'h00; end
            default: begin Op = 6'h3F; Func = 6'h2A; end
        endcase
    endtask

    function automatic logic [21:0] exp_dec(input int cls);
        logic [1:0] rd = 2'd0, as = 2'd0, mr = 2'd0;
        logic [7:0] ex = 8'd0, op = 8'd0;
        case (cls)
            C_ADD:  rd = 2'd1;
            C_SUB:  begin rd = 2'd1; op = 8'd1; end
            C_ORI:  begin as = 2'd1; op = 8'd2; end
            C_LUI:  begin as = 2'd1; ex = 8'd2; op = 8'd3; end
            C_LW:   begin as = 2'd1; mr = 2'd1; ex = 8'd1; end
            C_SW:   begin as = 2'd1; ex = 8'd1; end
            C_BEQ:  begin ex = 8'd1; op = 8'd1; end
            C_JAL:  begin rd = 2'd2; mr = 2'd2; end
            C_MFC0: mr = 2'd3;
            default: ;
        endcase
        return {rd, as, mr, ex, op};
    endfunction

    // Reference model: walk one instruction through its phase list, checking every cycle
    task automatic run_instr(input int cls, input int ifw, input int mw, input bit az);
        bit rdy, to;
        int code, nxt;
        logic pcw, cp;
        logic [3:0] ps;
        code = 0;
        set_ir(cls);
        for (int k = 0; k <= ifw; k++) begin
            rdy = (k == ifw);
            to  = EXC_ON && !rdy && (k == TO - 1);
            mem_ready = rdy;
            alu_zero  = 1'($urandom);
            cyc("if", 3'd0, 1, rdy, rdy, 4'd0, 0, 0, 0, 0);
            if (to) begin
                code = 7;
                break;
            end
        end
        if (code == 0) begin
            mem_ready = 1'($urandom);
            chk("decode", 32'(w_dec), 32'(exp_dec(cls)));
            cyc("id", 3'd1, 0, 0, 0, 4'd0, 0, 0, 0, 0);
            alu_zero  = az;
            mem_ready = 1'($urandom);
            pcw = 0; ps = 4'd0; cp = 0; nxt = 0;
            case (cls)
                C_BEQ:  begin pcw = az; ps = 4'd1; end
                C_JR:   begin pcw = 1; ps = 4'd3; end
                C_ERET: begin pcw = 1; ps = 4'd4; end
                C_JAL:  begin pcw = 1; ps = 4'd2; nxt = 1; end
                C_ADD, C_SUB, C_ORI, C_LUI, C_MFC0: nxt = 1;
                C_LW, C_SW: nxt = 2;
                C_MTC0: cp = 1;
                C_SYS:  if (EXC_ON) code = 8;
                C_RSV:  if (EXC_ON) code = 10;
                default: ;
            endcase
            cyc("ex", 3'd2, 0, 0, pcw, ps, 0, 0, cp, 0);
            if (nxt == 2) begin
                for (int k = 0; k <= mw; k++) begin
                    rdy = (k == mw);
                    to  = EXC_ON && !rdy && (k == TO - 1);
                    mem_ready = rdy;
                    alu_zero  = 1'($urandom);
                    cyc("mem", 3'd3, 1, 0, 0, 4'd0, 0, (cls == C_SW) && !to, 0, 0);
                    if (to) begin
                        code = 7;
                        break;
                    end
                end
                if (code == 0 && cls == C_LW) nxt = 1;
            end
            if (nxt == 1 && code == 0) begin
                mem_ready = 1'($urandom);
                cyc("wb", 3'd4, 0, 0, 0, 4'd0, 1, 0, 0, 0);
            end
        end
        if (code != 0) begin
            mem_ready = 1'($urandom);
            chk("exc_code", 32'(exc_code), 32'(code));
            cyc("exc", 3'd5, 0, 0, 1, 4'd5, 0, 0, 0, 1);
        end else begin
            model_ret = (model_ret + 1) % (1 << RW);
        end
        chk("retired", 32'(retired), 32'(model_ret));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b1;
        alu_zero = 1'b1;
        set_ir(C_LW);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_outs", 32'(w_outs), 32'h0);
        chk("rst_retired", 32'(retired), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("release_outs", 32'(w_outs), 32'h0);
        @(posedge clk);
        #1;
        model_ret = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int r0;
        int wrap_seq[5];
        wrap_seq = '{1, 2, 3, 0, 1};

        tbl.push_back('{C_LW,   0, 0, 1'b0, 5, 1});
        tbl.push_back('{C_BEQ,  0, 0, 1'b0, 3, 1});
        tbl.push_back('{C_BEQ,  0, 0, 1'b1, 3, 1});
        tbl.push_back('{C_SW,   0, 3, 1'b0, 7, 1});
        tbl.push_back('{C_ADD,  0, 0, 1'b0, 4, 1});
        tbl.push_back('{C_SUB,  1, 0, 1'b0, 5, 1});
        tbl.push_back('{C_ORI,  0, 0, 1'b0, 4, 1});
        tbl.push_back('{C_LUI,  0, 0, 1'b0, 4, 1});
        tbl.push_back('{C_JAL,  0, 0, 1'b0, 4, 1});
        tbl.push_back('{C_JR,   0, 0, 1'b0, 3, 1});
        tbl.push_back('{C_MFC0, 0, 0, 1'b0, 4, 1});
        tbl.push_back('{C_MTC0, 0, 0, 1'b0, 3, 1});
        tbl.push_back('{C_ERET, 2, 0, 1'b0, 5, 1});
        tbl.push_back('{C_NOP,  0, 0, 1'b0, 3, 1});
        tbl.push_back('{C_LW,   2, 1, 1'b0, 8, 1});
`ifdef MC_CTRL_UNIT_EXC_EN
        tbl.push_back('{C_SYS,  0, 0, 1'b0, 4, 0});
        tbl.push_back('{C_RSV,  0, 0, 1'b0, 4, 0});
        tbl.push_back('{C_ADD,  6, 0, 1'b0, 5, 0});
        tbl.push_back('{C_SW,   0, 5, 1'b0, 8, 0});
        tbl.push_back('{C_LW,   0, 3, 1'b0, 8, 1});
`else
        tbl.push_back('{C_SYS,  0, 0, 1'b0, 3, 1});
        tbl.push_back('{C_RSV,  0, 0, 1'b0, 3, 1});
        tbl.push_back('{C_ADD,  6, 0, 1'b0, 10, 1});
        tbl.push_back('{C_SW,   0, 5, 1'b0, 9, 1});
        tbl.push_back('{C_LW,   0, 3, 1'b0, 8, 1});
`endif

        reset = 1'b0;
        Op = 6'h0; Func = 6'h0; rs = 5'h0;
        alu_zero = 1'b0; mem_ready = 1'b0;
        do_reset();

        foreach (tbl[i]) begin
            r0 = int'(retired);
            run_instr(tbl[i].cls, tbl[i].ifw, tbl[i].mw, tbl[i].az);
            chk("latency", 32'(mon_cnt), 32'(tbl[i].lat));
            chk("retire_delta", 32'(2'(int'(retired) - r0)), 32'(tbl[i].ret));
        end

        // Reset in the middle of a store's memory wait
        if (model_ret == 0) run_instr(C_NOP, 0, 0, 1'b0);
        set_ir(C_SW);
        mem_ready = 1'b1;
        cyc("sw_if", 3'd0, 1, 1, 1, 4'd0, 0, 0, 0, 0);
        mem_ready = 1'b0;
        cyc("sw_id", 3'd1, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        cyc("sw_ex", 3'd2, 0, 0, 0, 4'd0, 0, 0, 0, 0);
        cyc("sw_mem", 3'd3, 1, 0, 0, 4'd0, 0, 1, 0, 0);
        #2;
        chk("mw_before_rst", 32'(Memwrite), 32'h1);
        reset = 1'b0;
        #1;
        chk("async_rst_outs", 32'(w_outs), 32'h0);
        chk("async_rst_retired", 32'(retired), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("release2_outs", 32'(w_outs), 32'h0);
        @(posedge clk);
        #1;
        model_ret = 0;
        run_instr(C_ADD, 0, 0, 1'b0);

        // Retire counter wrap with RET_W=2, then syscall
        do_reset();
        for (int i = 0; i < 5; i++) begin
            run_instr(C_NOP, 0, 0, 1'b0);
            chk("wrap_seq", 32'(retired), 32'(wrap_seq[i]));
        end
        run_instr(C_SYS, 0, 0, 1'b0);

        for (int i = 0; i < 80; i++) begin
            run_instr(int'($urandom_range(0, 14)), int'($urandom_range(0, 5)),
                      int'($urandom_range(0, 5)), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
